// File: rtl/fdiv_pkg.sv
// fdiv_pkg: shared constants and FSM state type for the sequential
// single-precision divider (fdiv) and its normalizer (fnorm).
package fdiv_pkg;

    localparam int BIAS      = 127;
    localparam int EXP_MAX   = 255;
    localparam int QBITS_DEF = 26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DIV  = 2'd2,
        PACK = 2'd3
    } state_t;

endpackage

// File: rtl/fnorm.sv
// fnorm: combinational 24-bit leading-zero count and left normalize.
//   m   : input significand (hidden bit in bit 23)
//   sig : m shifted left so that bit 23 is set (all zero when m is zero)
//   lz  : number of leading zeros in m (24 when m is zero)
module fnorm
    import fdiv_pkg::*;
(
    input  logic [23:0] m,
    output logic [23:0] sig,
    output logic [4:0]  lz
);

    // Scanning upward lets the highest set bit overwrite lower ones.
    always_comb begin
        lz = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (m[i]) lz = 5'(23 - i);
        end
        sig = m << lz;
    end

endmodule

// File: rtl/fdiv.sv
// fdiv: sequential IEEE-754 single-precision divider, y = x1 / x2.
// Radix-2 restoring division, one quotient bit per clock, fixed latency
// of QBITS+2 cycles from the accepted start edge to the done pulse.
// Denormal inputs accepted, result truncated, denormal results produced,
// overflow saturates to signed infinity. No Inf/NaN decoding.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, sampled only while busy=0
//   x1, x2   : dividend / divisor, captured on the accepted start edge
//   busy     : operation in flight
//   done     : one-cycle pulse when y/ovf/dz update
//   y        : quotient, held until the next done
//   ovf, dz  : exponent overflow / divide by zero, held with y
module fdiv
    import fdiv_pkg::*;
#(
    parameter int QBITS = QBITS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        busy,
    output logic        done,
    output logic [31:0] y,
    output logic        ovf,
    output logic        dz
);

    localparam int CW = $clog2(QBITS);
    localparam logic signed [9:0] BIAS_S = 10'(BIAS);
    localparam logic signed [9:0] EMAX_S = 10'(EXP_MAX);

    state_t state, state_nx;
    logic [CW-1:0] cnt;

    logic [31:0]        a1, a2;
    logic [24:0]        r;
    logic [QBITS-1:0]   q;
    logic signed [9:0]  eq;

    logic        ss, z1, z2;
    logic [7:0]  e1, e2, e1eff, e2eff;
    logic [23:0] m1n, m2n;
    logic [4:0]  lz1, lz2;
    logic signed [9:0] ea1, ea2;

    assign ss = a1[31] ^ a2[31];
    assign z1 = (a1[30:0] == 31'd0);
    assign z2 = (a2[30:0] == 31'd0);
    assign e1 = a1[30:23];
    assign e2 = a2[30:23];
    assign e1eff = (e1 == 8'd0) ? 8'd1 : e1;
    assign e2eff = (e2 == 8'd0) ? 8'd1 : e2;

    fnorm u_norm1 (.m({e1 != 8'd0, a1[22:0]}), .sig(m1n), .lz(lz1));
    fnorm u_norm2 (.m({e2 != 8'd0, a2[22:0]}), .sig(m2n), .lz(lz2));

    assign ea1 = signed'({2'b00, e1eff}) - signed'({5'b00000, lz1});
    assign ea2 = signed'({2'b00, e2eff}) - signed'({5'b00000, lz2});

    assign busy = (state != IDLE);

    // ---- control FSM ----
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = NORM;
            NORM: state_nx = DIV;
            DIV:  if (cnt == CW'(QBITS - 1)) state_nx = PACK;
            PACK: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)               cnt <= '0;
        else if (state == NORM) cnt <= '0;
        else if (state == DIV)  cnt <= cnt + 1'b1;
    end

    // ---- datapath: capture, normalize, iterate ----
    logic        ge;
    logic [24:0] r_dif;

    assign ge    = (r >= {1'b0, m2n});
    assign r_dif = ge ? (r - {1'b0, m2n}) : r;

    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (start) begin
                a1 <= x1;
                a2 <= x2;
            end
            NORM: begin
                r  <= {1'b0, m1n};
                q  <= '0;
                eq <= ea1 - ea2 + BIAS_S;
            end
            DIV: begin
                r <= r_dif << 1;
                q <= {q[QBITS-2:0], ge};
            end
            default: ;
        endcase
    end

    // ---- pack: select significand, classify exponent ----
    logic signed [9:0] e_p, sh;
    logic [23:0]       sig_p;
    logic [31:0]       y_nx;
    logic              ovf_nx, dz_nx;

    always_comb begin
        // q lies in (0.5, 2); top bit decides whether one more shift is needed.
        sig_p  = q[QBITS-1] ? 24'(q >> (QBITS - 24)) : 24'(q >> (QBITS - 25));
        e_p    = q[QBITS-1] ? eq : eq - 10'sd1;
        sh     = 10'sd1 - e_p;
        y_nx   = {ss, 31'd0};
        ovf_nx = 1'b0;
        dz_nx  = 1'b0;
        if (z2) begin
            y_nx  = {ss, 8'hFF, 23'd0};
            dz_nx = 1'b1;
        end else if (z1) begin
            y_nx = {ss, 31'd0};
        end else if (e_p >= EMAX_S) begin
            y_nx   = {ss, 8'hFF, 23'd0};
            ovf_nx = 1'b1;
        end else if (e_p >= 10'sd1) begin
            y_nx = {ss, e_p[7:0], sig_p[22:0]};
        end else if (e_p > -10'sd23) begin
            y_nx = {ss, 8'h00, 23'(sig_p >> sh)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
            y    <= '0;
            ovf  <= 1'b0;
            dz   <= 1'b0;
        end else begin
            done <= (state == PACK);
            if (state == PACK) begin
                y   <= y_nx;
                ovf <= ovf_nx;
                dz  <= dz_nx;
            end
        end
    end

endmodule

// File: tb/tb_fdiv.sv
module tb_fdiv;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] x1, x2;
    logic        busy, done, ovf, dz;
    logic [31:0] y;

    int tests = 0;
    int fails = 0;

    fdiv dut (
        .clk(clk), .rst(rst), .start(start), .x1(x1), .x2(x2),
        .busy(busy), .done(done), .y(y), .ovf(ovf), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one division, return outputs at the done cycle, the number of
    // edges from the accept edge to done, and how many sampled cycles had busy=1.
    task automatic op(input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] ry, output logic ro, output logic rd,
                      output int lat, output int bcnt);
        @(negedge clk);
        x1 = a; x2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        ry = y; ro = ovf; rd = dz;
    endtask

    task automatic run_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ey, input logic eo, input logic ed);
        logic [31:0] ry;
        logic ro, rd;
        int lat, bcnt;
        op(a, b, ry, ro, rd, lat, bcnt);
        check({tag, "_lat"}, lat, 28);
        check({tag, "_y"}, ry, ey);
        check({tag, "_ovf"}, ro, eo);
        check({tag, "_dz"}, rd, ed);
    endtask

    initial begin
        logic [31:0] ry;
        logic ro, rd;
        int lat, bcnt, npulse;

        rst = 1'b1; start = 1'b0; x1 = '0; x2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_y", y, 0);
        check("rst_ovf", ovf, 0);
        check("rst_dz", dz, 0);

        // 6 / 2 with full handshake checks
        op(32'h40C00000, 32'h40000000, ry, ro, rd, lat, bcnt);
        check("six_lat", lat, 28);
        check("six_busycnt", bcnt, 28);
        check("six_busy_at_done", busy, 0);
        check("six_y", ry, 32'h40400000);
        check("six_ovf", ro, 0);
        check("six_dz", rd, 0);
        @(posedge clk); #1;
        check("six_done_pulse", done, 0);
        check("six_y_held", y, 32'h40400000);

        run_case("negsix", 32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0);
        run_case("third",  32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0);
        run_case("dz_one", 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1);
        run_case("dz_zz",  32'h00000000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1);
        run_case("dz_neg", 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b0, 1'b1);
        run_case("zero_n", 32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1'b0);
        run_case("ovf",    32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1, 1'b0);
        run_case("den_a",  32'h00800000, 32'h40000000, 32'h00400000, 1'b0, 1'b0);
        run_case("den_b",  32'h00400000, 32'h3F000000, 32'h00800000, 1'b0, 1'b0);
        run_case("den_c",  32'h00800000, 32'h4B800000, 32'h00000000, 1'b0, 1'b0);

        // start pulse mid-operation must be ignored
        @(negedge clk);
        x1 = 32'h40C00000; x2 = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = 0;
        repeat (5) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        x1 = 32'h3F800000; x2 = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat++;
        while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
        check("ign_lat", lat, 28);
        check("ign_y", y, 32'h40400000);

        // new start issued in the done cycle is accepted
        check("dc_done", done, 1);
        op(32'h3F800000, 32'h40400000, ry, ro, rd, lat, bcnt);
        check("dc_lat", lat, 28);
        check("dc_y", ry, 32'h3EAAAAAA);

        // reset mid-operation discards the result
        @(negedge clk);
        x1 = 32'h40C00000; x2 = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_y", y, 0);
        check("abort_ovf", ovf, 0);
        npulse = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) npulse++;
        end
        check("abort_nopulse", npulse, 0);
        check("abort_y_hold", y, 0);

        run_case("recover", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
